// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter for ALU and load writeback sources.
// Round-robin grant, one-cycle registered write stage, read-port forwarding.
module reg_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             a_valid_i,
    input  logic [4:0]       a_rd_i,
    input  logic [XLEN-1:0]  a_data_i,
    output logic             a_ready_o,
    input  logic             b_valid_i,
    input  logic [4:0]       b_rd_i,
    input  logic [XLEN-1:0]  b_data_i,
    output logic             b_ready_o,
    output logic             wen_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  data_o,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    output logic             fwd1_hit_o,
    output logic [XLEN-1:0]  fwd1_data_o,
    output logic             fwd2_hit_o,
    output logic [XLEN-1:0]  fwd2_data_o,
    output logic [CNT_W-1:0] wr_count_o
);

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    grant_e          last_q;
    grant_e          last_d;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            wen_d;

    // Round-robin grant: on a tie the source not granted last wins.
    always_comb begin
        a_ready_o = a_valid_i & (~b_valid_i | (last_q == GNT_B));
        b_ready_o = b_valid_i & (~a_valid_i | (last_q == GNT_A));
    end

    // Mux the winning request and work out the next grant owner.
    always_comb begin
        xfer     = 1'b0;
        sel_rd   = 5'd0;
        sel_data = '0;
        last_d   = last_q;
        unique case (1'b1)
            a_ready_o: begin
                xfer     = 1'b1;
                sel_rd   = a_rd_i;
                sel_data = a_data_i;
                last_d   = GNT_A;
            end
            b_ready_o: begin
                xfer     = 1'b1;
                sel_rd   = b_rd_i;
                sel_data = b_data_i;
                last_d   = GNT_B;
            end
            default: ;
        endcase
        wen_d = xfer & (sel_rd != 5'd0);
    end

    // Grant owner, registered write stage and committed-write counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= GNT_B;
            wen_o      <= 1'b0;
            rd_o       <= 5'd0;
            data_o     <= '0;
            wr_count_o <= '0;
        end else begin
            last_q <= last_d;
            wen_o  <= wen_d;
            if (xfer) begin
                rd_o   <= sel_rd;
                data_o <= sel_data;
            end
            if (wen_d) begin
                wr_count_o <= wr_count_o + 1'b1;
            end
        end
    end

    // Bypass the staged write to both read ports while the regfile catches up.
    always_comb begin
        fwd1_hit_o  = wen_o & (rd_o == rs1_i) & (rs1_i != 5'd0);
        fwd2_hit_o  = wen_o & (rd_o == rs2_i) & (rs2_i != 5'd0);
        fwd1_data_o = data_o;
        fwd2_data_o = data_o;
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter.
// A second instance with a 4-bit counter exercises wrap-around.
module tb_reg_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        a_valid_i;
    logic [4:0]  a_rd_i;
    logic [31:0] a_data_i;
    logic        b_valid_i;
    logic [4:0]  b_rd_i;
    logic [31:0] b_data_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;

    logic        a_ready_o, b_ready_o, wen_o;
    logic [4:0]  rd_o;
    logic [31:0] data_o, fwd1_data_o, fwd2_data_o, wr_count_o;
    logic        fwd1_hit_o, fwd2_hit_o;

    logic        s_a_ready, s_b_ready, s_wen;
    logic [4:0]  s_rd;
    logic [31:0] s_data, s_f1_data, s_f2_data;
    logic        s_f1_hit, s_f2_hit;
    logic [3:0]  s_cnt;

    int passes = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    reg_wb_arbiter #(.XLEN(32), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_valid_i(a_valid_i), .a_rd_i(a_rd_i), .a_data_i(a_data_i),
        .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i),
        .b_ready_o(b_ready_o),
        .wen_o(wen_o), .rd_o(rd_o), .data_o(data_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i),
        .fwd1_hit_o(fwd1_hit_o), .fwd1_data_o(fwd1_data_o),
        .fwd2_hit_o(fwd2_hit_o), .fwd2_data_o(fwd2_data_o),
        .wr_count_o(wr_count_o)
    );

    reg_wb_arbiter #(.XLEN(32), .CNT_W(4)) dut_s (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_valid_i(a_valid_i), .a_rd_i(a_rd_i), .a_data_i(a_data_i),
        .a_ready_o(s_a_ready),
        .b_valid_i(b_valid_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i),
        .b_ready_o(s_b_ready),
        .wen_o(s_wen), .rd_o(s_rd), .data_o(s_data),
        .rs1_i(rs1_i), .rs2_i(rs2_i),
        .fwd1_hit_o(s_f1_hit), .fwd1_data_o(s_f1_data),
        .fwd2_hit_o(s_f2_hit), .fwd2_data_o(s_f2_data),
        .wr_count_o(s_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    // Hand-computed contention schedule: A rd 1..4 advancing on accept,
    // B rd 10 held; grants A,B,A,B.
    logic       exp_ar [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_br [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] exp_rd [4] = '{5'd1, 5'd10, 5'd2, 5'd10};

    initial begin
        logic [4:0] a_idx;
        rst_ni    = 1'b0;
        a_valid_i = 1'b0;
        a_rd_i    = 5'd0;
        a_data_i  = 32'd0;
        b_valid_i = 1'b0;
        b_rd_i    = 5'd0;
        b_data_i  = 32'd0;
        rs1_i     = 5'd0;
        rs2_i     = 5'd0;

        #3;
        chk("rst_wen", wen_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_cnt", wr_count_o, 0);

        @(negedge clk_i);
        rst_ni = 1'b1;

        // Contention right after reset: first tie goes to A.
        a_idx = 5'd1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                chk("cont_wen", wen_o, 1);
                chk("cont_rd", rd_o, exp_rd[i-1]);
            end
            a_valid_i = 1'b1;
            a_rd_i    = a_idx;
            a_data_i  = {27'd0, a_idx} * 32'h11111111;
            b_valid_i = 1'b1;
            b_rd_i    = 5'd10;
            b_data_i  = 32'h0B0B0B0B;
            #1;
            chk("cont_ar", a_ready_o, exp_ar[i]);
            chk("cont_br", b_ready_o, exp_br[i]);
            if (exp_ar[i]) a_idx = a_idx + 5'd1;
            @(negedge clk_i);
        end
        chk("cont_wen4", wen_o, 1);
        chk("cont_rd4", rd_o, 10);
        chk("cont_data4", data_o, 32'h0B0B0B0B);
        chk("cont_cnt", wr_count_o, 4);
        idle();

        // Single source A.
        a_valid_i = 1'b1;
        a_rd_i    = 5'd5;
        a_data_i  = 32'hDEADBEEF;
        #1;
        chk("single_ar", a_ready_o, 1);
        chk("single_br", b_ready_o, 0);
        @(negedge clk_i);
        chk("single_wen", wen_o, 1);
        chk("single_rd", rd_o, 5);
        chk("single_data", data_o, 32'hDEADBEEF);
        chk("single_cnt", wr_count_o, 5);
        idle();
        @(negedge clk_i);
        chk("hold_wen", wen_o, 0);
        chk("hold_rd", rd_o, 5);
        chk("hold_data", data_o, 32'hDEADBEEF);

        // x0 write is accepted but dropped.
        b_valid_i = 1'b1;
        b_rd_i    = 5'd0;
        b_data_i  = 32'h12345678;
        #1;
        chk("x0_br", b_ready_o, 1);
        @(negedge clk_i);
        idle();
        rs1_i = 5'd0;
        #1;
        chk("x0_wen", wen_o, 0);
        chk("x0_cnt", wr_count_o, 5);
        chk("x0_fwd1", fwd1_hit_o, 0);
        chk("x0_fdata", fwd1_data_o, 32'h12345678);
        @(negedge clk_i);

        // Forwarding to both read ports.
        a_valid_i = 1'b1;
        a_rd_i    = 5'd7;
        a_data_i  = 32'hA5A5A5A5;
        @(negedge clk_i);
        idle();
        rs1_i = 5'd7;
        rs2_i = 5'd7;
        #1;
        chk("fwd_h1", fwd1_hit_o, 1);
        chk("fwd_h2", fwd2_hit_o, 1);
        chk("fwd_d1", fwd1_data_o, 32'hA5A5A5A5);
        chk("fwd_d2", fwd2_data_o, 32'hA5A5A5A5);
        rs1_i = 5'd8;
        #1;
        chk("fwd_miss1", fwd1_hit_o, 0);
        chk("fwd_keep2", fwd2_hit_o, 1);
        chk("fwd_cnt", wr_count_o, 6);
        @(negedge clk_i);
        rs1_i = 5'd0;
        rs2_i = 5'd0;

        // 11 more writes: 17 in total, 4-bit counter wraps to 1.
        a_valid_i = 1'b1;
        a_rd_i    = 5'd3;
        a_data_i  = 32'h33;
        repeat (11) @(negedge clk_i);
        chk("wrap_big", wr_count_o, 17);
        chk("wrap_small", s_cnt, 1);
        chk("wrap_wen", wen_o, 1);

        // Async reset mid-cycle with A still requesting.
        a_rd_i = 5'd9;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_wen", wen_o, 0);
        chk("arst_cnt", wr_count_o, 0);
        chk("arst_rd", rd_o, 0);
        @(negedge clk_i);
        chk("arst_wen2", wen_o, 0);
        rst_ni    = 1'b1;
        b_valid_i = 1'b1;
        b_rd_i    = 5'd4;
        #1;
        chk("arst_tie_a", a_ready_o, 1);
        chk("arst_tie_b", b_ready_o, 0);
        @(negedge clk_i);
        idle();
        chk("arst_wr_rd", rd_o, 9);
        chk("arst_wr_cnt", wr_count_o, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
